// File: rtl/inst_fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch buffer: defaults, FIFO entry
// layout and fetch FSM encoding.
package inst_fetch_buffer_pkg;

  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned ENTRY_W          = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries with flush, push, pop and occupancy.
// Flush wins over push/pop; push while full is accepted only alongside a pop.
module fetch_fifo
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               do_push;
  logic               do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = fetch_entry_t'(mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= ENTRY_W'(push_data);
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch front end: issues credit-limited word fetches, buffers
// returned instructions with their pc, and drops stale responses after a redirect.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst,
  input  logic        inst_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  logic          req_accept;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  logic [CW-1:0] inflight_nxt;
  logic [CW-1:0] fifo_count_nxt;
  logic [CW-1:0] discard_calc;
  logic [SW-1:0] credit_sum;

  // Handshakes and next-cycle occupancy used for the fetch credit decision.
  always_comb begin
    req_accept     = mem_req_valid && mem_req_ready;
    rsp_ok         = mem_rsp_valid && (inflight != '0);
    push           = rsp_ok && (state == RUN) && !redirect_valid;
    pop            = inst_valid && inst_ready && !redirect_valid;
    inflight_nxt   = inflight + CW'(req_accept) - CW'(rsp_ok);
    fifo_count_nxt = fifo_count + CW'(push) - CW'(pop);
    credit_sum     = SW'(inflight_nxt) + SW'(fifo_count_nxt);
    discard_calc   = inflight + CW'(mem_req_valid) - CW'(rsp_ok);
  end

  assign push_entry = '{pc: rsp_pc, inst: mem_rsp_data};
  assign inst_valid = !fifo_empty;
  assign inst_pc    = head_entry.pc;
  assign inst       = head_entry.inst;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // fetch_pc is the address of the next new request; rsp_pc the pc of the next kept response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      fetch_pc      <= RESET_PC;
      rsp_pc        <= RESET_PC;
      inflight      <= '0;
      discard_cnt   <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      inflight <= inflight_nxt;

      // An unaccepted request is held untouched, even across a redirect.
      if (!mem_req_valid || mem_req_ready) begin
        if (!redirect_valid && (credit_sum < SW'(DEPTH))) begin
          mem_req_valid <= 1'b1;
          mem_req_addr  <= fetch_pc;
          fetch_pc      <= fetch_pc + 32'd4;
        end else begin
          mem_req_valid <= 1'b0;
        end
      end

      if (redirect_valid) begin
        fetch_pc    <= word_align(redirect_pc);
        rsp_pc      <= word_align(redirect_pc);
        discard_cnt <= discard_calc;
        state       <= (discard_calc != '0) ? DRAIN : RUN;
      end else if (rsp_ok) begin
        if (state == DRAIN) begin
          discard_cnt <= discard_cnt - CW'(1);
          if (discard_cnt == CW'(1)) state <= RUN;
        end else begin
          rsp_pc <= rsp_pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: doc/inst_fetch_buffer.md
INST_FETCH_BUFFER -- requirements
Module: inst_fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning buffer entries and maximum in-flight fetch credit (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 redirect_valid  input  1  taken branch/jump from npc; restart fetch.
REQ-006 redirect_pc  input  32  new fetch address.
REQ-007 mem_req_valid  output  1  fetch request to instruction memory.
REQ-008 mem_req_addr  output  32  word-aligned fetch byte address.
REQ-009 mem_req_ready  input  1  memory accepts request.
REQ-010 mem_rsp_valid  input  1  instruction word returned, in request order.
REQ-011 mem_rsp_data  input  32  returned instruction.
REQ-012 inst_valid  output  1  buffered instruction available to decode.
REQ-013 inst_pc  output  32  address of inst.
REQ-014 inst  output  32  instruction word.
REQ-015 inst_ready  input  1  decode consumes the head entry.

Function
REQ-016 Request handshake SHALL complete when mem_req_valid && mem_req_ready; mem_req_valid/mem_req_addr SHALL be registered and held stable until accepted, even across a redirect.
REQ-017 A new request SHALL be raised only when pending + inflight + fifo_count < DEPTH (pending = unaccepted request, inflight = accepted request with no response yet).
REQ-018 fetch_pc SHALL advance by 4 per accepted request, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 Memory SHALL return exactly one response per accepted request, no earlier than the cycle after acceptance; the block SHALL accept mem_rsp_valid unconditionally.
REQ-020 Buffer SHALL be a FIFO of {pc, inst}; a response is pushed with the pc of its request; the head is presented on inst_pc/inst with inst_valid = !empty.
REQ-021 Pop SHALL occur on inst_valid && inst_ready; push and pop in the same cycle SHALL be legal at any occupancy, including full and empty (empty + push: data visible next cycle, not same cycle).
REQ-022 FSM states: RUN (all responses kept) and DRAIN (discard_cnt > 0; responses dropped, discard_cnt decremented); DRAIN -> RUN when discard_cnt reaches 0; new requests SHALL still issue in DRAIN.
REQ-023 On redirect_valid: FIFO flushed, any pop that cycle ignored; fetch_pc <= {redirect_pc[31:2], 2'b00}; discard_cnt <= inflight + pending - (mem_rsp_valid ? 1 : 0) (a response arriving in the redirect cycle is dropped); state <= DRAIN if that count > 0, else RUN.
REQ-024 Redirect SHALL take priority over push, pop and fetch_pc increment in the same cycle; a redirect while in DRAIN recomputes discard_cnt per REQ-023.
REQ-025 No request SHALL be raised in the redirect cycle; the first post-redirect request SHALL appear the following cycle if credit permits.
REQ-026 Response with mem_rsp_valid while inflight = 0 SHALL be ignored (protocol error, assertion in bench).

Reset
REQ-027 While rst = 0 at a clock edge: fetch_pc <= RESET_PC, FIFO empty, pending/inflight/discard_cnt <= 0, state <= RUN, mem_req_valid <= 0, inst_valid = 0, mem_req_addr/inst_pc/inst <= 0.
REQ-028 Reset mid-operation SHALL abandon all in-flight requests without draining; the memory model is reset together with the block.
REQ-029 First request SHALL be raised in the first cycle after rst returns to 1, with address RESET_PC.

Structure
REQ-030 Shared head package SHALL hold RESET_PC default, DEPTH default and the fifo entry width (64).
REQ-031 One sub-module, fetch_fifo (synchronous FIFO with flush, push, pop, count), SHALL be instantiated; counters and FSM stay in inst_fetch_buffer.

Verification
REQ-032 Reset release, ready=1, 1-cycle memory latency, inst_ready=1 -> requests 0x0,0x4,0x8,... back to back; inst_pc sequence 0x0,0x4,0x8 with matching words.
REQ-033 inst_ready=0, memory always ready -> exactly 4 requests (0x0..0xC), fifo full, mem_req_valid low until first pop, then one request (0x10).
REQ-034 Three requests inflight, redirect_pc=0x0000_1002 -> next request address 0x1000, three stale responses dropped, first inst_pc = 0x1000.
REQ-035 Redirect in same cycle as full-fifo pop and a response -> fifo empty next cycle, response dropped, discard_cnt = inflight-1.
REQ-036 mem_req_ready=0 for 5 cycles with redirect on cycle 2 -> mem_req_addr stable until accepted; that response discarded.
REQ-037 redirect_pc=0xFFFF_FFF8 -> fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
